// File: rtl/cpu_pkg.sv
// Shared CPU definitions: I/O-subset opcode constants and the control-unit state encoding.
package cpu_pkg;

  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [2:0] {RESET, T0, T1, T2, T3, HALT} state_t;

  function automatic logic is_legal(input logic [4:0] opc);
    return (opc == OPC_IN) || (opc == OPC_OUT) || (opc == OPC_NOP) || (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/io_control_unit.sv
// Moore control unit sequencing fetch (T0-T2) and execute (T3) for in/out/nop/halt.
// Optional IO_WAIT_EN: stall T3 of in/out until in_ready/out_ack.
module io_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             stop,
  input  logic             in_ready,
  input  logic             out_ack,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rin,
  output logic             Rout,
  output logic             InPortOut,
  output logic             OutPort,
  output logic             run,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [4:0] opcode;
  logic       io_done;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

`ifdef IO_WAIT_EN
  assign io_done = (opcode == OPC_IN)  ? in_ready :
                   (opcode == OPC_OUT) ? out_ack  : 1'b1;
`else
  logic unused_io;
  assign unused_io = in_ready ^ out_ack;
  assign io_done   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= RESET;
      wait_cnt  <= '0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        RESET: state <= T0;
        T0: begin
          state    <= T1;
          wait_cnt <= '0;
        end
        T1: begin
          if (wait_cnt == MEM_WAIT[3:0]) state <= T2;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        T2: state <= T3;
        T3: begin
          if (io_done) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
            if (!is_legal(opcode)) illegal <= 1'b1;
            state <= (opcode == OPC_HALT || stop) ? HALT : T0;
          end
        end
        HALT:    state <= HALT;
        default: state <= RESET;
      endcase
    end
  end

  // Execute strobes must see the IR loaded on the T2 exit edge, so the
  // strobes are decoded from the state register rather than pre-registered.
  always_comb begin
    {PCout, MARin, IncPC, Zin}           = '0;
    {Zlowout, PCin, Read, MDRin}         = '0;
    {MDRout, IRin}                       = '0;
    {Gra, Rin, Rout, InPortOut, OutPort} = '0;
    run = 1'b0;
    case (state)
      T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        run = 1'b1;
      end
      T1: begin
        {Zlowout, Read, MDRin} = '1;
        PCin = (wait_cnt == 4'd0);
        run  = 1'b1;
      end
      T2: begin
        {MDRout, IRin} = '1;
        run = 1'b1;
      end
      T3: begin
        run = 1'b1;
        if (opcode == OPC_IN)  {Gra, Rin, InPortOut} = '1;
        if (opcode == OPC_OUT) {Gra, Rout, OutPort}  = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_control_unit.sv
// Bench for io_control_unit: instruction-level reference model, a small datapath, directed and random stimulus.
module tb_io_control_unit;
  import cpu_pkg::*;

  localparam int MW = 1;

  logic        clk = 1'b0;
  logic        clear = 1'b1, stop = 1'b0, in_ready = 1'b1, out_ack = 1'b1;
  logic [31:0] ir_reg = '0;
  logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic        Gra, Rin, Rout, InPortOut, OutPort, run, illegal;
  logic [15:0] instr_cnt;

  io_control_unit #(.MEM_WAIT(MW), .CNT_W(16)) dut (
    .clk(clk), .clear(clear), .IR(ir_reg), .stop(stop), .in_ready(in_ready), .out_ack(out_ack),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Rin(Rin), .Rout(Rout),
    .InPortOut(InPortOut), .OutPort(OutPort), .run(run), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: mode 0 = reset, 1 = running, 2 = halted; m_k = cycle within instruction.
  int          m_mode = 0;
  int          m_k = 0;
  logic [4:0]  m_op = '0;
  logic [15:0] m_cnt = '0;
  logic        m_ill = 1'b0;
  logic [31:0] prog[$];

  function automatic logic [31:0] rand_word();
    logic [4:0] op;
    int r;
    r = $urandom % 16;
    if (r < 5)       op = OPC_IN;
    else if (r < 10) op = OPC_OUT;
    else if (r < 13) op = OPC_NOP;
    else if (r == 13) op = 5'($urandom % 22);
    else if (r == 14) op = OPC_HALT;
    else             op = OPC_NOP;
    return {op, 27'($urandom)};
  endfunction

  function automatic bit io_ok(input logic [4:0] op);
`ifdef IO_WAIT_EN
    if (op == OPC_IN)  return in_ready;
    if (op == OPC_OUT) return out_ack;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (clear) begin
      m_mode = 0; m_k = 0; m_cnt = '0; m_ill = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_k = 0;
    end else if (m_mode == 1) begin
      if (m_k < 3 + MW) begin
        if (m_k == 2 + MW) begin
          w = (prog.size() > 0) ? prog.pop_front() : rand_word();
          ir_reg <= w;
          m_op = w[31:27];
        end
        m_k++;
      end else if (io_ok(m_op)) begin
        m_cnt++;
        if (!(m_op inside {OPC_IN, OPC_OUT, OPC_NOP, OPC_HALT})) m_ill = 1'b1;
        if (m_op == OPC_HALT || stop) m_mode = 2;
        else m_k = 0;
      end
    end
  end

  function automatic logic [16:0] exp_ctl();
    logic r, t0, t1, t2, t3, xi, xo;
    r  = (m_mode == 1);
    t0 = r && m_k == 0;
    t1 = r && m_k >= 1 && m_k <= 1 + MW;
    t2 = r && m_k == 2 + MW;
    t3 = r && m_k == 3 + MW;
    xi = t3 && m_op == OPC_IN;
    xo = t3 && m_op == OPC_OUT;
    return {t0, t0, t0, t0, t1, r && m_k == 1, t1, t1, t2, t2, xi | xo, xi, xo, xi, xo, r, m_ill};
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("ctl", 32'({PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
                      Gra, Rin, Rout, InPortOut, OutPort, run, illegal}), 32'(exp_ctl()));
      chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
    end
  end

  // Minimal datapath driven by the strobes.
  logic [31:0] R [16] = '{default: '0};
  logic [31:0] pc = '0, outport_q = '0, inport = '0;

  always @(posedge clk) begin
    if (PCin) pc <= pc + 32'd4;
    if (Gra && Rin && InPortOut) R[ir_reg[26:23]] <= inport;
    if (Gra && Rout && OutPort) outport_q <= R[ir_reg[26:23]];
  end

  initial begin
    int rd, pci, op_cnt, t3c, hcnt;

    tick(1);
    started = 1'b1;
    tick(2);
    chk("reset_run", 32'(run), 32'd0);
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    clear = 1'b0;
    prog.push_back(32'hB0800000);
    inport = 32'h55;
    tick(1);
    chk("t0_strobes", 32'({PCout, MARin, IncPC, Zin}), 32'hF);

    rd = 0; pci = 0;
    for (int i = 0; i < 5; i++) begin
      rd += int'(Read); pci += int'(PCin);
      tick(1);
    end
    chk("read_cycles", 32'(rd), 32'd2);
    chk("pcin_cycles", 32'(pci), 32'd1);
    chk("pc_after_in", pc, 32'd4);
    chk("r1_after_in", R[1], 32'h55);
    chk("cnt_after_in", 32'(instr_cnt), 32'd1);

    prog.push_back(32'hB8800000);
    op_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      op_cnt += int'(OutPort);
      tick(1);
    end
    chk("outport_cycles", 32'(op_cnt), 32'd1);
    chk("outport_data", outport_q, 32'h55);
    chk("back_to_t0", 32'(PCout), 32'd1);

    prog.push_back(32'hF8000000);
    prog.push_back(32'hD0000000);
    tick(5);
    chk("illegal_set", 32'(illegal), 32'd1);
    tick(5);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    chk("cnt_after_nop", 32'(instr_cnt), 32'd4);

    prog.push_back(32'hD0000000);
    prog.push_back(32'hD8000000);
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(3);
    chk("stop_ignored_run", 32'(run), 32'd1);
    chk("stop_ignored_t0", 32'(PCout), 32'd1);
    tick(5);
    chk("halt_run", 32'(run), 32'd0);
    chk("halt_cnt", 32'(instr_cnt), 32'd6);
    tick(4);
    chk("halt_frozen", 32'(instr_cnt), 32'd6);
    clear = 1'b1;
    tick(1);
    chk("clear_cnt", 32'(instr_cnt), 32'd0);
    chk("clear_illegal", 32'(illegal), 32'd0);
    clear = 1'b0;
    tick(1);
    chk("restart_t0", 32'(PCout), 32'd1);

`ifdef IO_WAIT_EN
    prog.push_back(32'hB0800000);
    inport = 32'h77;
    in_ready = 1'b0;
    tick(4);
    t3c = 0;
    for (int i = 0; i < 3; i++) begin
      t3c += int'(Rin);
      tick(1);
    end
    t3c += int'(Rin);
    in_ready = 1'b1;
    tick(1);
    chk("stall_t3_cycles", 32'(t3c), 32'd4);
    chk("stall_r1", R[1], 32'h77);
    chk("stall_cnt", 32'(instr_cnt), 32'd1);
    prog.push_back(32'hB0800000);
    inport = 32'h99;
    in_ready = 1'b0;
    tick(5);
    chk("stall_held", 32'(InPortOut), 32'd1);
    clear = 1'b1;
    tick(1);
    chk("abort_run", 32'(run), 32'd0);
    chk("abort_cnt", 32'(instr_cnt), 32'd0);
    chk("abort_r1", R[1], 32'h77);
    clear = 1'b0;
    in_ready = 1'b1;
`endif

    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      hcnt = (m_mode == 2) ? hcnt + 1 : 0;
      clear    = (hcnt > 3) || (($urandom % 150) == 0);
      stop     = (($urandom % 12) == 0);
      in_ready = 1'($urandom % 2);
      out_ack  = (($urandom % 3) != 0);
      inport   = $urandom;
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
